// File: rtl/uart_tx_queue_if.sv
// Store-path / transmitter-side signal bundle for uart_tx_queue.
// The flush strobe exists only when UART_TXQ_FLUSH_EN is defined.
interface uart_tx_queue_if #(
   parameter int unsigned DEPTH = 16
);
   logic                   wr_en;
   logic [7:0]             wr_data;
   logic                   clr_overflow;
`ifdef UART_TXQ_FLUSH_EN
   logic                   flush;
`endif
   logic                   tx_start;
   logic [7:0]             tx_data;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;
   logic                   busy;
   logic                   overflow;

   modport master (
`ifdef UART_TXQ_FLUSH_EN
      output flush,
`endif
      output wr_en, wr_data, clr_overflow,
      input  tx_start, tx_data, full, empty, count, busy, overflow
   );

   modport slave (
`ifdef UART_TXQ_FLUSH_EN
      input  flush,
`endif
      input  wr_en, wr_data, clr_overflow,
      output tx_start, tx_data, full, empty, count, busy, overflow
   );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO ahead of the UART transmitter; launches are paced by a frame timer.
// UART_TXQ_FLUSH_EN adds a synchronous queue flush input.
module uart_tx_queue #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned FRAME_CYCLES = 10
) (
   input  logic           UART_CLK,
   input  logic           reset,
   uart_tx_queue_if.slave bus
);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned TimerW = $clog2(FRAME_CYCLES);
   // IDLE spends one cycle before the next launch, so WAIT lasts FRAME_CYCLES-1 cycles.
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(FRAME_CYCLES - 2);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic [7:0]        mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              overflow_q, overflow_d;
   logic              full, empty, push, pop, drop, flush_req;

`ifdef UART_TXQ_FLUSH_EN
   assign flush_req = bus.flush;
`else
   assign flush_req = 1'b0;
`endif

   assign full  = (count_q == CntW'(DEPTH));
   assign empty = (count_q == '0);
   // A flush outranks a same-cycle write, which is then neither stored nor counted as dropped.
   assign push  = bus.wr_en && !full && !flush_req;
   assign drop  = bus.wr_en && full && !flush_req;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && !flush_req) begin
               pop     = 1'b1;
               timer_d = TimerLoad;
               state_d = StWait;
            end
         end
         StWait: begin
            if (timer_q == '0) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tx_start_d = pop;
      tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
      overflow_d = drop | (overflow_q & ~bus.clr_overflow);
      if (flush_req) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge UART_CLK or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; occupancy alone decides which entries are valid.
   always_ff @(posedge UART_CLK) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count_q;
   assign bus.busy     = (state_q == StWait);
   assign bus.overflow = overflow_q;
endmodule
